// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and byte-steering helper for the data-memory arbiter.
// A word is transferred as four bytes, most significant byte first.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int   BYTES_PER_WORD = 4;
  localparam logic PORT_CPU       = 1'b0;
  localparam logic PORT_DBG       = 1'b1;

  // idx counts from the most significant byte: idx 0 selects bits 31:24.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter: combinational grant, with a registered
// pointer to the most recent owner that advances when a transaction completes.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_port_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // On a tie, the port that did not go last wins. Reset points at the debug
  // port so the CPU port wins the first tie.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == PORT_CPU) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (done_i) begin
      last_d = done_port_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a byte-wide single-port data memory between two word requesters,
// moving each granted word as four sequential big-endian byte accesses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,

  output logic              busy
);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

  logic [1:0]          arb_gnt;
  logic                arb_done;
  logic [DATA_W-1:0]   assembled;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       ({p1_req, p0_req}),
    .done_i      (arb_done),
    .done_port_i (owner_q),
    .gnt_o       (arb_gnt)
  );

  // The last byte of a read arrives in the same cycle the word is published.
  assign assembled = {shift_q[DATA_W-1:8], mem_rdata};
  assign arb_done  = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          owner_d = arb_gnt[1];
          we_d    = arb_gnt[1] ? p1_we    : p0_we;
          addr_d  = arb_gnt[1] ? p1_addr  : p0_addr;
          wdata_d = arb_gnt[1] ? p1_wdata : p0_wdata;
          cnt_d   = 2'd0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (!we_q) begin
          case (cnt_q)
            2'd0:    shift_d[31:24] = mem_rdata;
            2'd1:    shift_d[23:16] = mem_rdata;
            2'd2:    shift_d[15:8]  = mem_rdata;
            default: shift_d[7:0]   = mem_rdata;
          endcase
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == PORT_DBG) begin
              p1_rdata_d = assembled;
            end else begin
              p0_rdata_d = assembled;
            end
          end
        end
      end

      DONE: begin
        cnt_d   = 2'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      owner_q    <= PORT_CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      shift_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Memory-side outputs are forced to zero outside the byte-transfer window.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (state_q == XFER) begin
      mem_addr = addr_q + ADDR_W'(cnt_q);
      if (we_q) begin
        mem_we    = 1'b1;
        mem_wdata = byte_of(wdata_q, cnt_q);
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign p0_gnt   = busy && (owner_q == PORT_CPU);
  assign p1_gnt   = busy && (owner_q == PORT_DBG);
  assign p0_done  = (state_q == DONE) && (owner_q == PORT_CPU);
  assign p1_done  = (state_q == DONE) && (owner_q == PORT_DBG);
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

  // Ownership is exclusive, and the memory is only written by the owner.
  assert property (@(posedge clk) disable iff (!rst_n) !(p0_gnt && p1_gnt));
  assert property (@(posedge clk) disable iff (!rst_n) mem_we |-> (p0_gnt || p1_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural byte memory, vector table
// with a read scoreboard, and hand-written arbitration/reset sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [4:0]  p0_addr = '0;
  logic [31:0] p0_wdata = '0;
  logic        p0_gnt, p0_done;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [4:0]  p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic        p1_gnt, p1_done;
  logic [31:0] p1_rdata;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  int passCount = 0;
  int totalCount = 0;

  logic [7:0]  mem [32];
  logic [7:0]  model [32];
  logic [31:0] sbQ [$];
  logic [31:0] expRdata [2];

  typedef struct {
    logic        port;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expWord;
  } vec_t;

  vec_t vecs [9];

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_done   (p0_done),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_done   (p1_done),
    .p1_rdata  (p1_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Byte memory: cleared once, then written on rising edges by the DUT.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic we,
                               input logic [4:0] addr, input logic [31:0] wdata);
    if (port == 1'b0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // One complete transaction on a single port; called at #1 after a rising edge
  // with the DUT in IDLE. When scramble is set, addr/wdata change after the grant.
  task automatic runTxn(input logic port, input logic we, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expWord, input bit scramble);
    int cycles = 0;
    int weCycles = 0;
    bit seenDone = 0;
    bit bothGnt = 0;
    logic [4:0] a;
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        a = addr + 5'(k);
        model[a] = wdata[31 - 8*k -: 8];
      end
    end else begin
      sbQ.push_back(expWord);
    end
    applyStimulus(port, 1'b1, we, addr, wdata);
    while (!seenDone && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (scramble && cycles == 1) applyStimulus(port, 1'b1, we, addr + 5'd8, ~wdata);
      if (mem_we) weCycles++;
      if (p0_gnt && p1_gnt) bothGnt = 1;
      if (port ? p1_done : p0_done) seenDone = 1;
    end
    checkOutput("done latency (edges after IDLE sample)", cycles, 5);
    checkOutput("mem_we cycles", weCycles, we ? 4 : 0);
    checkOutput("gnt overlap", 32'(bothGnt), 0);
    checkOutput("owner gnt in DONE", 32'(port ? p1_gnt : p0_gnt), 1);
    checkOutput("other gnt in DONE", 32'(port ? p0_gnt : p1_gnt), 0);
    if (!we && sbQ.size() > 0) expRdata[port] = sbQ.pop_front();
    checkOutput("p0_rdata", p0_rdata, expRdata[0]);
    checkOutput("p1_rdata", p1_rdata, expRdata[1]);
    if (we || scramble) begin
      for (int k = 0; k < 32; k++) checkOutput($sformatf("mem[%0d]", k), 32'(mem[k]), 32'(model[k]));
    end
    @(posedge clk); #1;
    checkOutput("done pulse width", 32'(port ? p1_done : p0_done), 0);
    applyStimulus(port, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int n;
    int cyc;
    int dones;
    int order [4];
    int doneAt [4];
    bit bothGnt;
    logic prevP0, prevP1;

    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    expRdata[0] = '0;
    expRdata[1] = '0;

    vecs[0] = '{1'b0, 1'b1, 5'd4,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 5'd4,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 5'd30, 32'h11223344, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 5'd30, 32'h0,        32'h11223344};
    vecs[4] = '{1'b1, 1'b1, 5'd12, 32'hCAFEF00D, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 5'd12, 32'h0,        32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 5'd30, 32'h0,        32'h11223344};
    vecs[7] = '{1'b1, 1'b1, 5'd31, 32'h01020304, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h02030400};

    // Reset values
    #1;
    checkOutput("reset p0_gnt", 32'(p0_gnt), 0);
    checkOutput("reset p1_gnt", 32'(p1_gnt), 0);
    checkOutput("reset done", 32'({p0_done, p1_done}), 0);
    checkOutput("reset mem_we", 32'(mem_we), 0);
    checkOutput("reset mem_addr", 32'(mem_addr), 0);
    checkOutput("reset mem_wdata", 32'(mem_wdata), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset p0_rdata", p0_rdata, 0);
    checkOutput("reset p1_rdata", p1_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Both ports requesting continuously straight out of reset
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd8, 32'd0);
    n = 0; dones = 0; cyc = 0; bothGnt = 0;
    prevP0 = 1'b0; prevP1 = 1'b0;
    while (dones < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (p0_gnt && p1_gnt) bothGnt = 1;
      if (p0_gnt && !prevP0 && n < 4) begin order[n] = 0; n++; end
      if (p1_gnt && !prevP1 && n < 4) begin order[n] = 1; n++; end
      if (p0_done || p1_done) begin doneAt[dones] = cyc; dones++; end
      prevP0 = p0_gnt; prevP1 = p1_gnt;
    end
    checkOutput("contention done count", dones, 4);
    checkOutput("contention gnt overlap", 32'(bothGnt), 0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("grant order %0d", i), order[i], i % 2);
    for (int i = 1; i < 4; i++) checkOutput($sformatf("done spacing %0d", i), doneAt[i] - doneAt[i-1], 6);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

    // Vector table through the read scoreboard
    for (int i = 0; i < 9; i++) begin
      runTxn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expWord, 1'b0);
    end
    checkOutput("scoreboard drained", sbQ.size(), 0);

    // Requester inputs change mid-transfer; latched values must be written
    runTxn(1'b0, 1'b1, 5'd8, 32'h55667788, 32'h0, 1'b1);

    // Reset during a port 0 write at cnt=2
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd20, 32'hA1B2C3D4);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("cnt2 mem_addr", 32'(mem_addr), 22);
    checkOutput("cnt2 mem_we", 32'(mem_we), 1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("abort p0_gnt", 32'(p0_gnt), 0);
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort mem_we", 32'(mem_we), 0);
    checkOutput("abort mem_addr", 32'(mem_addr), 0);
    checkOutput("abort mem_wdata", 32'(mem_wdata), 0);
    checkOutput("abort p0_rdata", p0_rdata, 0);
    checkOutput("abort p1_rdata", p1_rdata, 0);
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (p0_done || p1_done) n++;
    end
    checkOutput("abort no done", n, 0);
    checkOutput("abort mem[20]", 32'(mem[20]), 32'hA1);
    checkOutput("abort mem[21]", 32'(mem[21]), 32'hB2);
    checkOutput("abort mem[22]", 32'(mem[22]), 32'h00);
    checkOutput("abort mem[23]", 32'(mem[23]), 32'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Port 0 went last before the abort; reset must restore port 0 priority
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 32'd0);
    @(posedge clk); #1;
    checkOutput("post-reset p0_gnt", 32'(p0_gnt), 1);
    checkOutput("post-reset p1_gnt", 32'(p1_gnt), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
